// File: rtl/mdio_master.sv
// Clause-22 MDIO management station: turns Wishbone single reads and writes
// into MDC/MDIO frames and returns the PHY's read data (err when nobody answers).
`timescale 1ns/1ps
module mdio_master #(
  parameter int MDC_HALF      = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  output logic        ack,
  output logic        err,
  output logic        mdc,
  output logic        mdo,
  output logic        mdo_en,
  input  logic        mdi
);

  localparam int              PH_W     = $clog2(MDC_HALF);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(MDC_HALF - 1);
  localparam logic [5:0]      PRE_LAST = 6'(PREAMBLE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase;
  logic [5:0]      bit_cnt;
  logic [15:0]     tx_sr;
  logic [15:0]     wdata_q;
  logic [15:0]     rx_sr;
  logic            is_read;
  logic            ta_err;
  logic            req;
  logic            half_end;

  assign req      = cyc && stb;
  assign half_end = (phase == PH_LAST);

  // ST, OP, PHYAD, REGAD left-aligned; tx_sr[15] is always the bit on the line.
  function automatic logic [15:0] frame_header(input logic write, input logic [9:0] a);
    frame_header = {2'b01, (write ? 2'b01 : 2'b10), a, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      mdc       <= 1'b0;
      mdo       <= 1'b1;
      mdo_en    <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      data_read <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          mdc       <= 1'b0;
          mdo       <= 1'b1;
          mdo_en    <= 1'b0;
          data_read <= '0;
          if (req) begin
            is_read <= !we;
            wdata_q <= data_write;
            ta_err  <= 1'b0;
            phase   <= '0;
            bit_cnt <= '0;
            mdo_en  <= 1'b1;
            tx_sr   <= frame_header(we, addr);
            if (PREAMBLE_BITS > 0) begin
              state <= S_PRE;
              mdo   <= 1'b1;
            end else begin
              state <= S_HDR;
              mdo   <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          data_read <= '0;
        end

        default: begin
          if (!half_end) begin
            phase <= phase + 1'b1;
          end else if (!mdc) begin
            // Rising MDC: the PHY's bit has been stable for the whole low phase.
            phase <= '0;
            mdc   <= 1'b1;
            if (state == S_TA && bit_cnt[0])
              ta_err <= mdi;
            if (state == S_DATA)
              rx_sr <= {rx_sr[14:0], mdi};
          end else begin
            phase <= '0;
            mdc   <= 1'b0;
            case (state)
              S_PRE: begin
                if (bit_cnt == PRE_LAST) begin
                  state   <= S_HDR;
                  bit_cnt <= '0;
                  mdo     <= tx_sr[15];
                end else begin
                  bit_cnt <= bit_cnt + 6'd1;
                  mdo     <= 1'b1;
                end
              end

              S_HDR: begin
                if (bit_cnt == 6'd13) begin
                  state   <= S_TA;
                  bit_cnt <= '0;
                  mdo     <= 1'b1;
                  mdo_en  <= !is_read;
                end else begin
                  bit_cnt <= bit_cnt + 6'd1;
                  mdo     <= tx_sr[14];
                  tx_sr   <= {tx_sr[14:0], 1'b0};
                end
              end

              S_TA: begin
                if (bit_cnt == 6'd1) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
                  tx_sr   <= wdata_q;
                  mdo     <= is_read ? 1'b1 : wdata_q[15];
                end else begin
                  bit_cnt <= 6'd1;
                  mdo     <= is_read;
                end
              end

              S_DATA: begin
                if (bit_cnt == 6'd15) begin
                  state   <= S_DONE;
                  bit_cnt <= '0;
                  mdo     <= 1'b1;
                  mdo_en  <= 1'b0;
                  // A master that abandoned the cycle gets no completion pulse.
                  if (req) begin
                    if (is_read && ta_err) begin
                      err       <= 1'b1;
                      data_read <= 16'hFFFF;
                    end else begin
                      ack       <= 1'b1;
                      data_read <= is_read ? rx_sr : 16'h0000;
                    end
                  end
                end else begin
                  bit_cnt <= bit_cnt + 6'd1;
                  mdo     <= is_read ? 1'b1 : tx_sr[14];
                  tx_sr   <= {tx_sr[14:0], 1'b0};
                end
              end

              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: scoreboard of expected completions plus a PHY model on
// the MDIO line; a second instance covers preamble suppression.
`timescale 1ns/1ps
module tb_mdio_master;

  localparam int H         = 2;
  localparam int P         = 32;
  localparam int NB        = P + 32;
  localparam int FRAME_CYC = NB * 2 * H;
  localparam int NP_CYC    = 32 * 2 * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [9:0]  addr;
  logic [15:0] data_write, data_read;
  logic        ack, err, mdc, mdo, mdo_en, mdi;

  logic        cyc_np, stb_np, we_np;
  logic [9:0]  addr_np;
  logic [15:0] data_np, data_read_np;
  logic        ack_np, err_np, mdc_np, mdo_np, mdo_en_np, mdi_np;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  typedef struct {
    logic        exp_err;
    logic [15:0] exp_data;
    logic [63:0] exp_bits;
    logic [63:0] exp_en;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  logic        phy_mode = 1'b0;
  logic [15:0] phy_data = 16'h0000;
  logic        phy_drv  = 1'b0;
  logic        phy_bit  = 1'b1;
  logic        prev_mdc = 1'b0;
  int          low_run  = 1000;
  int          rise_cnt = 0;
  logic [63:0] cap_bits = '0;
  logic [63:0] cap_en   = '0;

  assign mdi    = mdo_en ? mdo : (phy_drv ? phy_bit : 1'b1);
  assign mdi_np = mdo_en_np ? mdo_np : 1'b1;

  mdio_master #(.MDC_HALF(H), .PREAMBLE_BITS(P)) u_dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
    .data_write(data_write), .data_read(data_read), .ack(ack), .err(err),
    .mdc(mdc), .mdo(mdo), .mdo_en(mdo_en), .mdi(mdi)
  );

  mdio_master #(.MDC_HALF(H), .PREAMBLE_BITS(0)) u_np (
    .clk(clk), .rst(rst), .cyc(cyc_np), .stb(stb_np), .we(we_np), .addr(addr_np),
    .data_write(data_np), .data_read(data_read_np), .ack(ack_np), .err(err_np),
    .mdc(mdc_np), .mdo(mdo_np), .mdo_en(mdo_en_np), .mdi(mdi_np)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build(input logic w, input logic [4:0] p, input logic [4:0] r,
                                input logic [15:0] d, output logic [63:0] b,
                                output logic [63:0] en);
    logic [31:0] f;
    f = {2'b01, (w ? 2'b01 : 2'b10), p, r, 2'b10, d};
    for (int i = 0; i < 32; i++) begin
      b[i]       = 1'b1;
      en[i]      = 1'b1;
      b[32 + i]  = f[31 - i];
      en[32 + i] = w ? 1'b1 : (i < 14);
    end
  endfunction

  // Line monitor, PHY model and scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (mdc && !prev_mdc) begin
      if (low_run > H) rise_cnt = 0;
      if (rise_cnt < 64) begin
        cap_bits[6'(rise_cnt)] = mdo;
        cap_en[6'(rise_cnt)]   = mdo_en;
      end
      rise_cnt++;
      if (phy_mode && rise_cnt == P + 15) begin
        phy_drv = 1'b1;
        phy_bit = 1'b0;
      end else if (phy_mode && rise_cnt >= P + 16 && rise_cnt < NB) begin
        phy_drv = 1'b1;
        phy_bit = phy_data[4'(NB - 1 - rise_cnt)];
      end else begin
        phy_drv = 1'b0;
        phy_bit = 1'b1;
      end
    end
    low_run  = mdc ? 0 : low_run + 1;
    prev_mdc = mdc;
    if (ack || err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {ack, err}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("ack", ack, !e.exp_err);
        chk("err", err, e.exp_err);
        chk("data_read", data_read, e.exp_data);
        chk("done_cycle", cyc_cnt, e.exp_cyc);
        chk("frame_len", rise_cnt, NB);
        chk("frame_mdo", cap_bits & e.exp_en, e.exp_bits & e.exp_en);
        chk("frame_mdo_en", cap_en, e.exp_en);
      end
    end
  end

  task automatic do_req(input logic w, input logic [4:0] p, input logic [4:0] r,
                        input logic [15:0] d, input logic rsp, input logic [15:0] rsp_data);
    exp_t e;
    logic seen;
    @(negedge clk);
    phy_mode = rsp;
    phy_data = rsp_data;
    build(w, p, r, d, e.exp_bits, e.exp_en);
    e.exp_err  = !w && !rsp;
    e.exp_data = w ? 16'h0000 : (rsp ? rsp_data : 16'hFFFF);
    e.exp_cyc  = cyc_cnt + 1 + FRAME_CYC;
    sb.push_back(e);
    we = w; addr = {p, r}; data_write = d; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    we = ~w; addr = ~{p, r}; data_write = ~d;
    seen = 1'b0;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      if (ack || err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cyc = 1'b0;
    stb = 1'b0;
    if (!seen) begin
      chk("req_timeout", 1'b0, 1'b1);
      if (sb.size() > 0) sb.delete(0);
    end
    @(negedge clk);
    chk("pulse_width", {ack, err}, 2'b00);
    chk("idle_lines", {mdc, mdo, mdo_en}, 3'b010);
    chk("idle_data_read", data_read, 16'h0000);
  endtask

  initial begin
    logic [63:0] gb, gen;
    int pulses, acc, t1, t2, nr;
    logic [31:0] fb;
    logic pm;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; data_write = '0;
    cyc_np = 1'b0; stb_np = 1'b0; we_np = 1'b0; addr_np = '0; data_np = '0;
    repeat (3) @(negedge clk);
    chk("reset_lines", {mdc, mdo, mdo_en, ack, err}, 5'b01000);
    chk("reset_data_read", data_read, 16'h0000);
    rst = 1'b0;

    do_req(1'b1, 5'd1,  5'd0,  16'h1234, 1'b0, 16'h0000);
    do_req(1'b0, 5'd3,  5'd2,  16'h0000, 1'b1, 16'hBEEF);
    do_req(1'b0, 5'd5,  5'd7,  16'h0000, 1'b0, 16'h0000);
    do_req(1'b1, 5'd31, 5'd31, 16'hA5C3, 1'b0, 16'h0000);
    do_req(1'b0, 5'd0,  5'd0,  16'h0000, 1'b1, 16'h0001);

    // Reset during bit 40 abandons the frame.
    @(negedge clk);
    phy_mode = 1'b0;
    we = 1'b1; addr = {5'd2, 5'd9}; data_write = 16'h5555; cyc = 1'b1; stb = 1'b1;
    repeat (1 + 40 * 2 * H) @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("midrst_lines", {mdc, mdo, mdo_en, ack, err}, 5'b01000);
    chk("midrst_data_read", data_read, 16'h0000);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      if (ack || err) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    do_req(1'b1, 5'd4, 5'd1, 16'h0F0F, 1'b0, 16'h0000);

    // Master drops the cycle at bit 10: frame completes on the wire, no pulse.
    @(negedge clk);
    phy_mode = 1'b0;
    build(1'b1, 5'd6, 5'd3, 16'h8001, gb, gen);
    we = 1'b1; addr = {5'd6, 5'd3}; data_write = 16'h8001; cyc = 1'b1; stb = 1'b1;
    repeat (10 * 2 * H) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    pulses = 0;
    for (int k = 0; k < FRAME_CYC + 10; k++) begin
      @(negedge clk);
      if (ack || err) pulses++;
    end
    chk("gated_no_pulse", pulses, 0);
    chk("gated_frame_len", rise_cnt, NB);
    chk("gated_frame_mdo", cap_bits & gen, gb & gen);
    do_req(1'b0, 5'd7, 5'd8, 16'h0000, 1'b1, 16'h7E81);

    // Preamble suppressed, request held high for two back-to-back frames.
    @(negedge clk);
    we_np = 1'b1; addr_np = {5'd1, 5'd0}; data_np = 16'hCAFE; cyc_np = 1'b1; stb_np = 1'b1;
    @(negedge clk);
    acc = cyc_cnt;
    chk("np_first_bit", {mdc_np, mdo_np, mdo_en_np}, 3'b001);
    t1 = -1; t2 = -1; nr = 0; fb = '0; pm = mdc_np;
    for (int k = 0; k < 3 * NP_CYC; k++) begin
      @(negedge clk);
      if (mdc_np && !pm && t1 < 0) begin
        fb = {fb[30:0], mdo_np};
        nr++;
      end
      pm = mdc_np;
      if (t1 >= 0 && cyc_cnt == t1 + 2)
        chk("np_restart", {mdc_np, mdo_np, mdo_en_np}, 3'b001);
      if (ack_np) begin
        if (t1 < 0) begin
          t1 = cyc_cnt;
        end else begin
          t2 = cyc_cnt;
          cyc_np = 1'b0;
          stb_np = 1'b0;
          break;
        end
      end
    end
    chk("np_ack1_cycle", t1, acc + NP_CYC);
    chk("np_ack2_cycle", t2, t1 + 2 + NP_CYC);
    chk("np_bit_count", nr, 32);
    chk("np_frame", fb, {2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'hCAFE});
    repeat (4) @(negedge clk);
    chk("np_idle", {mdc_np, mdo_np, mdo_en_np, ack_np, err_np}, 5'b01000);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
